// File: rtl/charlieplex_scanner.sv
// Frame-buffered charlieplex scan driver: double-buffered bitmap, one LED lit at a time,
// constant-length slots with a dark blanking gap and brightness as per-slot on-time.
module charlieplex_scanner #(
  parameter int unsigned PINCOUNT   = 4,
  parameter int unsigned BLANK      = 4,
  parameter int unsigned BRIGHTBITS = 8,
  localparam int unsigned LEDCOUNT  = PINCOUNT * (PINCOUNT - 1),
  localparam int unsigned INDEXBITS = $clog2(LEDCOUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEDCOUNT-1:0]   frame_in,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [BRIGHTBITS-1:0] brightness,
  output logic [INDEXBITS-1:0]  led_index,
  output logic                  led_enable,
  output logic                  frame_start
);

  localparam int unsigned ON        = (1 << BRIGHTBITS) - 1;
  localparam int unsigned BLANKBITS = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam int unsigned CNTBITS   = (BRIGHTBITS >= BLANKBITS) ? BRIGHTBITS : BLANKBITS;

  localparam logic [CNTBITS-1:0]   BLANK_LAST = CNTBITS'(BLANK - 1);
  localparam logic [CNTBITS-1:0]   ON_LAST    = CNTBITS'(ON - 1);
  localparam logic [INDEXBITS-1:0] IDX_LAST   = INDEXBITS'(LEDCOUNT - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  // Scan position registers describe the cycle about to be presented on the outputs.
  logic [0:0]            phase_q, phase_d;
  logic [CNTBITS-1:0]    cnt_q, cnt_d;
  logic [INDEXBITS-1:0]  idx_q, idx_d;
  logic [LEDCOUNT-1:0]   active_q, active_d;
  logic [LEDCOUNT-1:0]   pending_q, pending_d;
  logic                  pend_full_q, pend_full_d;
  logic [BRIGHTBITS-1:0] bri_q, bri_d;

  logic [INDEXBITS-1:0]  led_index_d;
  logic                  led_enable_d;
  logic                  frame_start_d;
  logic                  frame_ready_d;

  logic                  slot_entry;
  logic                  frame_entry;
  logic                  swap;
  logic                  accept;

  // Next-state and registered-output logic.
  always_comb begin
    phase_d       = phase_q;
    cnt_d         = cnt_q + CNTBITS'(1);
    idx_d         = idx_q;
    active_d      = active_q;
    pending_d     = pending_q;
    pend_full_d   = pend_full_q;
    bri_d         = bri_q;
    led_index_d   = idx_q;
    led_enable_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_ready_d = frame_ready;

    slot_entry  = (phase_q == ST_BLANK) && (cnt_q == '0);
    frame_entry = slot_entry && (idx_q == '0);
    swap        = frame_entry && pend_full_q;
    accept      = frame_valid && frame_ready;

    case (phase_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          phase_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          phase_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + INDEXBITS'(1);
        end
      end
      default: begin
        phase_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (slot_entry) begin
      bri_d = brightness;
    end
    if (swap) begin
      active_d = pending_q;
    end
    if (accept) begin
      pending_d = frame_in;
    end
    // ready is low whenever pending is full, so accept and swap never collide on pending.
    pend_full_d   = accept || (pend_full_q && !swap);
    frame_ready_d = !pend_full_d;
    frame_start_d = frame_entry;
    led_enable_d  = (phase_q == ST_ON) && active_q[idx_q] && (cnt_q < CNTBITS'(bri_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= ST_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      bri_q       <= '0;
      led_index   <= '0;
      led_enable  <= 1'b0;
      frame_start <= 1'b0;
      frame_ready <= 1'b1;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      bri_q       <= bri_d;
      led_index   <= led_index_d;
      led_enable  <= led_enable_d;
      frame_start <= frame_start_d;
      frame_ready <= frame_ready_d;
    end
  end

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Directed bench for charlieplex_scanner at default parameters (12 LEDs, 259-cycle slots).
module tb_charlieplex_scanner;

  localparam int LEDCOUNT = 12;
  localparam int BLANK    = 4;
  localparam int ON       = 255;
  localparam int SLOT     = BLANK + ON;
  localparam int FRAME    = LEDCOUNT * SLOT;

  logic        clk;
  logic        rst;
  logic [11:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  brightness;
  logic [3:0]  led_index;
  logic        led_enable;
  logic        frame_start;

  int checks;
  int errors;

  logic [11:0] offerq[$];

  typedef struct {
    logic [11:0] bm;
    int          bri;
    int          bri2;
    int          sw;
    int          exp_on;
  } vec_t;

  vec_t vecs[6];

  charlieplex_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .brightness  (brightness),
    .led_index   (led_index),
    .led_enable  (led_enable),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock; on an accepted offer, present the next queued frame or drop valid.
  task automatic tick();
    logic acc;
    acc = !rst && frame_valid && frame_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      if (offerq.size() > 0) frame_in = offerq.pop_front();
      else frame_valid = 1'b0;
    end
  endtask

  // Checks ncyc cycles from a frame_start cycle against the scan model; one comparison per slot.
  task automatic check_frame(input logic [11:0] bm, input int bri_a, input int bri_b,
                             input int sw, input int ncyc, output int on_cnt);
    int   mism;
    int   first;
    logic f_en;
    logic f_fs;
    logic [3:0] f_idx;
    logic x_en;
    on_cnt = 0;
    mism   = 0;
    first  = 0;
    f_en   = 1'b0;
    f_fs   = 1'b0;
    f_idx  = '0;
    x_en   = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      int   slot;
      int   off;
      int   bri;
      logic exp_en;
      slot   = c / SLOT;
      off    = c % SLOT;
      bri    = (slot < sw) ? bri_a : bri_b;
      exp_en = (off >= BLANK) && bm[4'(slot)] && ((off - BLANK) < bri);
      if (led_enable === 1'b1) on_cnt++;
      if (led_enable !== exp_en || led_index !== 4'(slot) || frame_start !== (c == 0)) begin
        if (mism == 0) begin
          first = c;
          f_en  = led_enable;
          f_idx = led_index;
          f_fs  = frame_start;
          x_en  = exp_en;
        end
        mism++;
      end
      if (off == SLOT - 1 || c == ncyc - 1) begin
        checks++;
        if (mism > 0) begin
          errors++;
          $display("FAIL slot %0d (bm=%03h): %0d bad cycles, first at %0d: en=%b idx=%0d fs=%b, expected en=%b idx=%0d fs=%b",
                   slot, bm, mism, first, f_en, f_idx, f_fs, x_en, slot, (first == 0));
        end
        mism = 0;
      end
      if (sw < LEDCOUNT && c == (sw - 1) * SLOT + 100) brightness = 8'(bri_b);
      if (c < ncyc - 1) tick();
    end
  endtask

  initial begin
    int cnt;
    checks = 0;
    errors = 0;
    cnt    = 0;
    // {bitmap, brightness, brightness after switch, switch slot, enable cycles per frame}
    vecs[0] = '{12'h020, 255, 255, 12, 255};
    vecs[1] = '{12'hFFF,  10,  10, 12, 120};
    vecs[2] = '{12'hFFF,   0,   0, 12, 0};
    vecs[3] = '{12'hFFF,  10, 200,  4, 1640};
    vecs[4] = '{12'h801,   1,   1, 12, 2};
    vecs[5] = '{12'h555, 255, 255, 12, 1530};

    rst         = 1'b1;
    frame_valid = 1'b1;
    frame_in    = 12'hABC;
    brightness  = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst led_enable", 32'(led_enable), 32'd0);
      check("rst led_index", 32'(led_index), 32'd0);
      check("rst frame_ready", 32'(frame_ready), 32'd1);
      check("rst frame_start", 32'(frame_start), 32'd0);
    end

    // First frame is offered on the release edge, coinciding with the (empty) slot-0 swap.
    frame_in = vecs[0].bm;
    rst      = 1'b0;
    tick();
    check("release frame_start", 32'(frame_start), 32'd1);
    check("accept at swap edge ready", 32'(frame_ready), 32'd0);
    check_frame(12'h000, 0, 0, 12, FRAME, cnt);
    check("frame0 dark on-count", 32'(cnt), 32'd0);

    for (int i = 0; i < 6; i++) begin
      brightness  = 8'(vecs[i].bri);
      frame_valid = 1'b1;
      if (i + 1 < 6) begin
        frame_in = vecs[i + 1].bm;
      end else begin
        frame_in = 12'h00C;
        offerq.push_back(12'h082);
        offerq.push_back(12'hFFF);
      end
      tick();
      check_frame(vecs[i].bm, vecs[i].bri, vecs[i].bri2, vecs[i].sw, FRAME, cnt);
      check($sformatf("vec%0d on-count", i), 32'(cnt), 32'(vecs[i].exp_on));
    end

    // Frame A (0x00C) is pending; B (0x082) has been offered for the whole frame.
    check("backpressure ready", 32'(frame_ready), 32'd0);
    check("backpressure B held", 32'(frame_valid), 32'd1);
    tick();
    check_frame(12'h00C, 255, 255, 12, FRAME, cnt);
    check("frame A on-count", 32'(cnt), 32'd510);
    check("junk held off ready", 32'(frame_ready), 32'd0);
    tick();
    check_frame(12'h082, 255, 255, 12, 7 * SLOT + BLANK + 20, cnt);
    check("slot7 lit before rst", 32'(led_enable), 32'd1);
    check("slot7 index", 32'(led_index), 32'd7);
    check("junk pending ready", 32'(frame_ready), 32'd0);

    rst = 1'b1;
    tick();
    check("midrst led_enable", 32'(led_enable), 32'd0);
    check("midrst led_index", 32'(led_index), 32'd0);
    check("midrst frame_ready", 32'(frame_ready), 32'd1);
    check("midrst frame_start", 32'(frame_start), 32'd0);
    rst         = 1'b0;
    frame_valid = 1'b0;
    offerq.delete();
    tick();
    check_frame(12'h000, 255, 255, 12, FRAME, cnt);
    check("post-rst dark on-count", 32'(cnt), 32'd0);
    check("post-rst ready", 32'(frame_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
